// File: rtl/mem_stage_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: FSM encodings and data-memory port widths.
package mem_stage_access_unit_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DMEM_DATA_W = 32;
    localparam int REG_ADDR_W  = 5;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles spent waiting on the data-memory slave; expire flags the final allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + CW'(1);
    end

    assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: issues load/store on the dmem req/ready port, stalls upstream while in flight,
// and registers the MEM/WB writeback payload.
module mem_stage_access_unit
    import mem_stage_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = DMEM_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ifWriteRegsFile,
    input  logic                  mem_ifWriteMem,
    input  logic                  mem_memOutOrAluOutWriteBackToRegFile,
    input  logic [REG_ADDR_W-1:0] mem_registerWriteAddress,
    input  logic [DATA_WIDTH-1:0] mem_aluOutput,
    input  logic [DATA_WIDTH-1:0] mem_registerRtOrZero,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_ifWriteRegsFile,
    output logic [REG_ADDR_W-1:0] wb_registerWriteAddress,
    output logic [DATA_WIDTH-1:0] wb_writeData,
    output logic                  misalign_err,
    output logic                  timeout_err
);
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  access, aligned, is_load;
    logic                  expire, timer_en, timer_clr;

    assign is_load = mem_memOutOrAluOutWriteBackToRegFile;
    assign access  = mem_ifWriteMem | is_load;
    assign aligned = (mem_aluOutput[1:0] == 2'b00);

    // Ready takes priority over expiry, so the counter is cleared by either completion path.
    assign timer_en  = (state_q == ST_BUSY);
    assign timer_clr = (state_q != ST_BUSY) || dmem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clr),
        .enable(timer_en),
        .expire(expire)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && aligned) begin
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (dmem_ready || expire)
                    state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                 <= ST_IDLE;
            rdata_q                 <= '0;
            dmem_req                <= 1'b0;
            dmem_we                 <= 1'b0;
            dmem_addr               <= '0;
            dmem_wdata              <= '0;
            wb_ifWriteRegsFile      <= 1'b0;
            wb_registerWriteAddress <= '0;
            wb_writeData            <= '0;
            misalign_err            <= 1'b0;
            timeout_err             <= 1'b0;
        end else begin
            state_q      <= state_d;
            misalign_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!access) begin
                        wb_ifWriteRegsFile      <= mem_ifWriteRegsFile;
                        wb_registerWriteAddress <= mem_registerWriteAddress;
                        wb_writeData            <= mem_aluOutput;
                    end else if (!aligned) begin
                        wb_ifWriteRegsFile <= 1'b0;
                        misalign_err       <= 1'b1;
                    end else begin
                        dmem_req           <= 1'b1;
                        dmem_we            <= mem_ifWriteMem;
                        dmem_addr          <= mem_aluOutput;
                        dmem_wdata         <= mem_registerRtOrZero;
                        wb_ifWriteRegsFile <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    wb_ifWriteRegsFile <= 1'b0;
                    if (dmem_ready) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                    end else if (expire) begin
                        rdata_q     <= '0;
                        dmem_req    <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // EX/MEM still holds the memory instruction; it retires at this edge.
                    wb_ifWriteRegsFile      <= mem_ifWriteRegsFile;
                    wb_registerWriteAddress <= mem_registerWriteAddress;
                    wb_writeData            <= is_load ? rdata_q : mem_aluOutput;
                end
                default: wb_ifWriteRegsFile <= 1'b0;
            endcase
        end
    end
endmodule
